// File: rtl/shift_alu_seq.sv
// Sequential execute unit: single-cycle logic/arith ops and multi-cycle
// shift/multiply ops, finishing with a one-cycle register-file write.
module shift_alu_seq #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [7:0]    opA,
  input  logic [7:0]    opB,
  input  logic [pw-1:0] dstIn,
  input  logic          scryIn,
  output logic          busy,
  output logic          done,
  output logic          writeEnable,
  output logic [pw-1:0] writeAddr,
  output logic [7:0]    result,
  output logic          scryOut,
  output logic          ngtvOut,
  output logic          zeroOut
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]    r_state;
  logic [2:0]    r_op;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [3:0]    r_cnt;
  logic          r_carry;
  logic [pw-1:0] r_dst;
  logic [15:0]   r_prod;
  logic [15:0]   r_mcand;
  logic [7:0]    r_result;
  logic          r_scry;
  logic          r_ngtv;
  logic          r_zero;
  logic [pw-1:0] r_waddr;

  logic [3:0]    w_cnt_init;
  logic [7:0]    w_res;
  logic          w_scry;

  // Iteration count loaded on acceptance
  always_comb begin
    w_cnt_init = 4'd0;
    case (op)
      OP_SHL, OP_SHR: w_cnt_init = {1'b0, opB[2:0]};
      OP_MUL:         w_cnt_init = 4'd8;
      default:        w_cnt_init = 4'd0;
    endcase
  end

  // Final result and shift-carry; r_carry starts as the latched scryIn so a
  // zero-length shift and all plain ALU ops pass the incoming flag through.
  always_comb begin
    w_res  = 8'd0;
    w_scry = r_carry;
    case (r_op)
      OP_ADD:         w_res = r_a + r_b;
      OP_SUB:         w_res = r_a - r_b;
      OP_AND:         w_res = r_a & r_b;
      OP_OR:          w_res = r_a | r_b;
      OP_XOR:         w_res = r_a ^ r_b;
      OP_SHL, OP_SHR: w_res = r_a;
      OP_MUL: begin
        w_res  = r_prod[7:0];
        w_scry = (r_prod[15:8] != 8'd0);
      end
      default:        w_res = 8'd0;
    endcase
  end

  // Control FSM, datapath iteration and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_cnt    <= 4'd0;
      r_carry  <= 1'b0;
      r_dst    <= '0;
      r_prod   <= 16'd0;
      r_mcand  <= 16'd0;
      r_result <= 8'd0;
      r_scry   <= 1'b0;
      r_ngtv   <= 1'b0;
      r_zero   <= 1'b0;
      r_waddr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= opA;
            r_b     <= opB;
            r_dst   <= dstIn;
            r_carry <= scryIn;
            r_cnt   <= w_cnt_init;
            r_prod  <= 16'd0;
            r_mcand <= {8'd0, opA};
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
            case (r_op)
              OP_SHL: begin
                r_a     <= {r_a[6:0], 1'b0};
                r_carry <= r_a[7];
              end
              OP_SHR: begin
                r_a     <= {1'b0, r_a[7:1]};
                r_carry <= r_a[0];
              end
              OP_MUL: begin
                // LSB-first shift-add: multiplier bits consumed from r_b
                if (r_b[0]) begin
                  r_prod <= r_prod + r_mcand;
                end
                r_mcand <= {r_mcand[14:0], 1'b0};
                r_b     <= {1'b0, r_b[7:1]};
              end
              default: r_cnt <= 4'd0;
            endcase
          end else begin
            r_result <= w_res;
            r_scry   <= w_scry;
            r_ngtv   <= w_res[7];
            r_zero   <= (w_res == 8'd0);
            r_waddr  <= r_dst;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign writeEnable = (r_state == S_DONE);
  assign writeAddr   = r_waddr;
  assign result      = r_result;
  assign scryOut     = r_scry;
  assign ngtvOut     = r_ngtv;
  assign zeroOut     = r_zero;

endmodule

// File: tb/tb_shift_alu_seq.sv
// Scoreboard bench for shift_alu_seq: stimulus pushes expected writes, a
// negedge monitor pops and checks each write pulse including its cycle.
module tb_shift_alu_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] opA = 8'd0;
  logic [7:0] opB = 8'd0;
  logic [2:0] dstIn = 3'd0;
  logic       scryIn = 1'b0;
  logic       busy, done, writeEnable;
  logic [2:0] writeAddr;
  logic [7:0] result;
  logic       scryOut, ngtvOut, zeroOut;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] res;
    logic       scry;
    logic       ngtv;
    logic       zero;
    logic [2:0] addr;
    int         cyc;
  } exp_t;
  exp_t q[$];

  shift_alu_seq #(.pw(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .dstIn(dstIn), .scryIn(scryIn), .busy(busy), .done(done),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .result(result),
    .scryOut(scryOut), .ngtvOut(ngtvOut), .zeroOut(zeroOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (writeEnable === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got result=%0h addr=%0h expected no write", result, writeAddr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("scryOut", int'(scryOut), int'(e.scry));
        chk("ngtvOut", int'(ngtvOut), int'(e.ngtv));
        chk("zeroOut", int'(zeroOut), int'(e.zero));
        chk("writeAddr", int'(writeAddr), int'(e.addr));
        chk("done", int'(done), 1);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] d, input logic si, input int n,
                       input logic [7:0] er, input logic es, input logic en, input logic ez);
    exp_t e;
    int k;
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b; dstIn = d; scryIn = si;
    @(posedge clk);
    #1;
    e.res = er; e.scry = es; e.ngtv = en; e.zero = ez; e.addr = d; e.cyc = cyc + n + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_released", int'(busy), 0);
  endtask

  initial begin
    exp_t e;
    // Reset held for two edges with start asserted
    reset = 1'b0; start = 1'b1; op = 3'b000; opA = 8'h12; opB = 8'h34; dstIn = 3'd6; scryIn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(writeEnable), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_scry", int'(scryOut), 0);
    chk("rst_ngtv", int'(ngtvOut), 0);
    chk("rst_zero", int'(zeroOut), 0);
    chk("rst_addr", int'(writeAddr), 0);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);

    //     op      opA    opB    dst   scry N  result scry ngtv zero
    issue(3'b000, 8'h7F, 8'h01, 3'd5, 1'b1, 0, 8'h80, 1'b1, 1'b1, 1'b0);
    issue(3'b110, 8'h01, 8'h01, 3'd2, 1'b0, 1, 8'h00, 1'b1, 1'b0, 1'b1);
    issue(3'b101, 8'h81, 8'h03, 3'd1, 1'b1, 3, 8'h08, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 8'h5A, 8'h00, 3'd7, 1'b1, 0, 8'h5A, 1'b1, 1'b0, 1'b0);
    issue(3'b111, 8'h10, 8'h10, 3'd3, 1'b0, 8, 8'h00, 1'b1, 1'b0, 1'b1);
    issue(3'b111, 8'h0F, 8'h03, 3'd4, 1'b1, 8, 8'h2D, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 8'h05, 8'h07, 3'd0, 1'b0, 0, 8'hFE, 1'b0, 1'b1, 1'b0);
    issue(3'b010, 8'hF0, 8'h3C, 3'd6, 1'b1, 0, 8'h30, 1'b1, 1'b0, 1'b0);
    issue(3'b011, 8'h0F, 8'h30, 3'd2, 1'b0, 0, 8'h3F, 1'b0, 1'b0, 1'b0);
    issue(3'b100, 8'hA5, 8'hFF, 3'd3, 1'b0, 0, 8'h5A, 1'b0, 1'b0, 1'b0);
    issue(3'b110, 8'h80, 8'h0F, 3'd5, 1'b1, 7, 8'h01, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 8'hFF, 8'h07, 3'd1, 1'b0, 7, 8'h80, 1'b1, 1'b1, 1'b0);

    // Busy rejection: MUL accepted at E0, ADD held on start from E1 onward
    @(negedge clk);
    start = 1'b1; op = 3'b111; opA = 8'h0F; opB = 8'h11; dstIn = 3'd4; scryIn = 1'b1;
    @(posedge clk);
    #1;
    e.res = 8'hFF; e.scry = 1'b0; e.ngtv = 1'b1; e.zero = 1'b0; e.addr = 3'd4; e.cyc = cyc + 9;
    q.push_back(e);
    @(negedge clk);
    op = 3'b000; opA = 8'h01; opB = 8'h01; dstIn = 3'd3; scryIn = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    e.res = 8'h02; e.scry = 1'b0; e.ngtv = 1'b0; e.zero = 1'b0; e.addr = 3'd3; e.cyc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_rej_idle", int'(busy), 0);

    // Mid-operation reset of a MUL: no write may ever appear for it
    issue(3'b000, 8'h40, 8'h41, 3'd7, 1'b1, 0, 8'h81, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'b111; opA = 8'h03; opB = 8'h05; dstIn = 3'd2; scryIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_we", int'(writeEnable), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_flags", int'({scryOut, ngtvOut, zeroOut}), 0);
    chk("mid_rst_addr", int'(writeAddr), 0);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    chk("mid_rst_still_idle", int'(busy), 0);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
